// File: rtl/cpu_pkg.sv
// Shared definitions for the sequencer, decode stage and ALU: opcode map,
// control state encoding and ALU operation codes.
package cpu_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_AND   = 4'h3;
  localparam logic [3:0] OP_OR    = 4'h4;
  localparam logic [3:0] OP_XOR   = 4'h5;
  localparam logic [3:0] OP_SHL   = 4'h6;
  localparam logic [3:0] OP_SHR   = 4'h7;
  localparam logic [3:0] OP_LOAD  = 4'h8;
  localparam logic [3:0] OP_STORE = 4'h9;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEM       = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_HALT      = 3'd6
  } state_t;

  // ALU codes share the opcode values so the latched opcode drives the ALU directly
  typedef enum logic [3:0] {
    ALU_NONE = 4'h0,
    ALU_ADD  = 4'h1,
    ALU_SUB  = 4'h2,
    ALU_AND  = 4'h3,
    ALU_OR   = 4'h4,
    ALU_XOR  = 4'h5,
    ALU_SHL  = 4'h6,
    ALU_SHR  = 4'h7
  } alu_op_t;

  function automatic logic op_is_reserved(input logic [3:0] op);
    return (op >= 4'hA) && (op <= 4'hE);
  endfunction

endpackage

// File: rtl/control_opclass.sv
// Combinational opcode classifier used by the control sequencer.
module control_opclass
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       is_alu,
  output logic       is_load,
  output logic       is_store,
  output logic       is_halt,
  output logic       is_reserved
);

  always_comb begin
    is_alu      = (opcode >= OP_ADD) && (opcode <= OP_SHR);
    is_load     = (opcode == OP_LOAD);
    is_store    = (opcode == OP_STORE);
    is_halt     = (opcode == OP_HALT);
    is_reserved = op_is_reserved(opcode);
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle instruction sequencer: fetch/decode/execute/mem/writeback FSM
// with run/halt control and a retired-instruction counter.
module control_unit
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_run,
  input  logic [3:0]       i_opcode,
  input  logic             i_imem_valid,
  input  logic             i_dmem_ready,
  output logic             o_imem_req,
  output logic             o_ir_load,
  output logic             o_pc_en,
  output logic             o_reg_we,
  output logic             o_mem_re,
  output logic             o_mem_we,
  output logic             o_halted,
  output logic             o_illegal,
  output logic [3:0]       o_alu_op,
  output logic [2:0]       o_state,
  output logic [CNT_W-1:0] o_retired
);

  state_t           state;
  logic [3:0]       opcode_q;
  logic [CNT_W-1:0] retired_q;

  logic [3:0] class_op;
  logic       is_alu;
  logic       is_load;
  logic       is_store;
  logic       is_halt;
  logic       is_reserved;
  logic       is_nop_like;
  state_t     after_done;

  // The opcode register is only valid after DECODE, so classify the live field there
  assign class_op = (state == ST_DECODE) ? i_opcode : opcode_q;

  control_opclass u_opclass (
    .opcode      (class_op),
    .is_alu      (is_alu),
    .is_load     (is_load),
    .is_store    (is_store),
    .is_halt     (is_halt),
    .is_reserved (is_reserved)
  );

  assign is_nop_like = !(is_alu || is_load || is_store || is_halt);
  assign after_done  = i_run ? ST_FETCH : ST_IDLE;

  always_comb begin
    o_imem_req = 1'b0;
    o_ir_load  = 1'b0;
    o_pc_en    = 1'b0;
    o_reg_we   = 1'b0;
    o_mem_re   = 1'b0;
    o_mem_we   = 1'b0;
    o_halted   = 1'b0;
    o_illegal  = 1'b0;
    o_alu_op   = 4'h0;
    case (state)
      ST_FETCH: begin
        o_imem_req = 1'b1;
        o_ir_load  = i_imem_valid;
      end
      ST_DECODE: begin
        o_pc_en   = is_nop_like;
        o_illegal = is_reserved;
      end
      ST_EXECUTE: begin
        o_alu_op = opcode_q;
      end
      ST_MEM: begin
        o_mem_re = is_load;
        o_mem_we = is_store;
        o_pc_en  = is_store && i_dmem_ready;
      end
      ST_WRITEBACK: begin
        o_reg_we = 1'b1;
        o_pc_en  = 1'b1;
      end
      ST_HALT: begin
        o_halted = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign o_state   = state;
  assign o_retired = retired_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= ST_IDLE;
      opcode_q  <= 4'h0;
      retired_q <= '0;
    end else begin
      if (o_pc_en) begin
        retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      case (state)
        ST_IDLE: begin
          if (i_run) state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (i_imem_valid) state <= ST_DECODE;
        end
        ST_DECODE: begin
          opcode_q <= i_opcode;
          if (is_halt)           state <= ST_HALT;
          else if (is_nop_like)  state <= after_done;
          else                   state <= ST_EXECUTE;
        end
        ST_EXECUTE: begin
          state <= is_alu ? ST_WRITEBACK : ST_MEM;
        end
        ST_MEM: begin
          if (i_dmem_ready) state <= is_load ? ST_WRITEBACK : after_done;
        end
        ST_WRITEBACK: begin
          state <= after_done;
        end
        ST_HALT: begin
          if (!i_run) state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Handshake and exclusivity invariants
  a_ir_pc_excl: assert property (@(posedge i_clk) disable iff (i_reset)
    !(o_ir_load && o_pc_en));
  a_mem_excl: assert property (@(posedge i_clk) disable iff (i_reset)
    !(o_mem_re && o_mem_we));
  a_imem_hold: assert property (@(posedge i_clk) disable iff (i_reset)
    (o_imem_req && !i_imem_valid) |=> o_imem_req);
  a_dmem_hold: assert property (@(posedge i_clk) disable iff (i_reset)
    ((o_mem_re || o_mem_we) && !i_dmem_ready) |=> (o_mem_re || o_mem_we));

endmodule
